mux_bus_decoder: RTL and testbench
==================================

// Module: mux_bus_decoder
// PURPOSE
//  Parametrised demultiplexer and chip-select controller for the 8085-style multiplexed AD bus.
//  - Latches {a_hi,ad} during ALE and decodes NUM_CS regions (memory or IO space) into cs_n.
//  - Inserts per-region wait states through ready.
//  - Sits between the CPU core and peripherals (ROM/RAM/IO) and replaces hand-written decode.
// PARAMETERS
//  NUM_CS    2                 number of chip-select regions (1..8)
//  CS_BASE   {8'h01,8'h00}     packed NUM_CS x 8b; region i base for a_hi (index 0 = LSB byte)
//  CS_MASK   {8'hFF,8'hFF}     packed NUM_CS x 8b; compare bits (1 = compared)
//  CS_IO     2'b00             bit i = 1: region i answers IO cycles (io_mn=1); else memory cycles
//  WAIT_CYC  {4'd1,4'd0}       packed NUM_CS x 4b; wait states inserted for region i
//  TIMEOUT   64                watchdog limit in clk cycles (used only with BUS_WATCHDOG_EN)
// PORTS
//  clk       in   1       system clock (CPU clk_out)
//  resetn    in   1       synchronous, active-low reset
//  ale       in   1       address latch enable, active high
//  ad        in   8       multiplexed low address / data
//  a_hi      in   8       high address byte
//  io_mn     in   1       1 = IO cycle, 0 = memory cycle
//  rd_n      in   1       read strobe, active low
//  wr_n      in   1       write strobe, active low
//  address   out  16      latched address {a_hi,ad}
//  cs_n      out  NUM_CS  registered chip selects, active low, one-hot-low or all-high
//  hit       out  1       1 = latched address matched a region
//  ready     out  1       CPU READY; low = wait state
//  bus_err   out  1       sticky watchdog flag (tied 0 without BUS_WATCHDOG_EN)
// BEHAVIOUR
//  Reset (resetn=0 at posedge clk): address=0, cs_n=all 1, hit=0, ready=1, bus_err=0, state=IDLE.
//   Reset mid-cycle aborts immediately; the strobe must rise before any new wait sequence.
//  Latch: every posedge with ale=1, address <= {a_hi,ad}. The last ALE-high sample is kept.
//  Decode: region i matches when (a_hi^CS_BASE[i])&CS_MASK[i]==0 and io_mn==CS_IO[i].
//   - Lowest index wins on overlap.
//   - cs_n/hit update on the first posedge with ale=0 after ALE; held until next ALE cycle.
//   - No match: cs_n=all 1, hit=0.
//  strobe = ~rd_n | ~wr_n; a strobe edge is strobe=1 with the previous-cycle strobe=0.
//  FSM states IDLE, ADDR, WAIT, ACTIVE:
//   - IDLE  : ale=1 -> ADDR.
//   - ADDR  : strobe edge with hit and WAIT_CYC[sel]>0 -> WAIT, ready=0 from next cycle, cnt=WAIT_CYC[sel]-1.
//             strobe edge with no hit or WAIT_CYC=0 -> ACTIVE, ready stays 1.
//   - WAIT  : cnt counts down; ready=0 for exactly WAIT_CYC[sel] cycles, then ready=1 -> ACTIVE.
//   - ACTIVE: strobe=0 -> IDLE.
//   - Any state: ale=1 -> ADDR. ALE has priority over a simultaneous strobe edge; that edge is ignored.
//   - Strobe released during WAIT -> IDLE with ready=1 next cycle (no stuck READY).
//  rd_n and wr_n both low counts as one strobe, and no error is flagged.
//  Counter width is 4 bits and never wraps: it saturates at 0.
// CONFIGURATION
//  BUS_WATCHDOG_EN defined:
//   - A 16b counter runs while strobe=1 and state!=IDLE.
//   - When it reaches TIMEOUT: ready forced 1, state -> ACTIVE, bus_err <= 1 (sticky until reset).
//  BUS_WATCHDOG_EN undefined: no counter, bus_err tied 0, no forced release.
// STRUCTURE
//  Package mux_bus_pkg:
//   - typedef enum logic [1:0] bus_state_t {IDLE,ADDR,WAIT,ACTIVE}.
//   - localparam WAIT_W=4 and localparam MAX_CS=8.
//   - function region_match(base,mask,a_hi).
//  Sub-module ws_counter: load/decrement/zero-flag wait-state counter, reused by the watchdog (16b).
// TESTING
//  T1 reset: resetn=0 with ale=1 -> address=0, cs_n=2'b11, ready=1, hit=0 next edge.
//  T2 mem read region0: ale with a_hi=00,ad=34, then rd_n=0 -> address=0034, cs_n=2'b10, ready never low.
//  T3 wait states region1: a_hi=01, rd_n low -> cs_n=2'b01; ready=0 exactly 1 cycle, then 1 until rd_n rises.
//  T4 unmapped/IO: a_hi=80 memory -> hit=0, cs_n=11, no wait; a_hi=00 with io_mn=1 (CS_IO=00) -> no select.
//  T5 abort: WAIT_CYC=4'd5, rd_n released after 2 waits -> ready=1 next cycle, state IDLE.
//   Same setup with resetn pulsed mid-WAIT -> all outputs at reset values.
//  T6 watchdog (BUS_WATCHDOG_EN, WAIT_CYC=15, TIMEOUT=8): wr_n held low -> ready=1 at cycle 8, bus_err=1 until reset.

Source files
------------

// File: rtl/mux_bus_decoder_pkg.sv
// mux_bus_pkg: shared types and helpers for the multiplexed-bus decoder.
//   bus_state_t  : bus-cycle FSM state encoding
//   WAIT_W       : width of the per-region wait-state count
//   MAX_CS       : largest supported number of chip-select regions
//   region_match : masked compare of the high address byte against a region base
package mux_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    WAIT   = 2'd2,
    ACTIVE = 2'd3
  } bus_state_t;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned MAX_CS = 8;

  // A mask bit of 1 means that address bit takes part in the compare.
  function automatic logic region_match(input logic [7:0] base,
                                        input logic [7:0] mask,
                                        input logic [7:0] a_hi);
    return ((a_hi ^ base) & mask) == 8'h00;
  endfunction

endpackage

// File: rtl/mux_bus_decoder_if.sv
// mux_bus_decoder_if: CPU-side multiplexed AD bus.
//   ale    : address latch enable, active high
//   ad     : multiplexed low address / data
//   a_hi   : high address byte
//   io_mn  : 1 = IO cycle, 0 = memory cycle
//   rd_n   : read strobe, active low
//   wr_n   : write strobe, active low
//   ready  : READY back to the CPU, low = wait state
// master = CPU core, slave = decoder.
interface mux_bus_decoder_if;
  logic       ale;
  logic [7:0] ad;
  logic [7:0] a_hi;
  logic       io_mn;
  logic       rd_n;
  logic       wr_n;
  logic       ready;

  modport master (output ale, ad, a_hi, io_mn, rd_n, wr_n, input ready);
  modport slave  (input ale, ad, a_hi, io_mn, rd_n, wr_n, output ready);
endinterface

// File: rtl/mux_bus_decoder_ws_counter.sv
// ws_counter: loadable down-counter with terminal-count flag.
//   clk, resetn : clock, synchronous active-low reset
//   load_i      : load load_val_i (wins over dec_i)
//   dec_i       : decrement by one, holding at zero
//   load_val_i  : value to load
//   zero_o      : count is zero
// Used for wait-state timing and, at 16 bits, for the bus watchdog.
module ws_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_bus_decoder.sv
// mux_bus_decoder: address demultiplexer, chip-select decoder and wait-state
// generator for an 8085-style multiplexed AD bus.
//   clk      : system clock
//   resetn   : synchronous active-low reset
//   bus      : CPU bus (slave side), see mux_bus_decoder_if
//   address  : latched {a_hi, ad}
//   cs_n     : registered chip selects, active low, one-hot-low or all high
//   hit      : latched address matched a region
//   bus_err  : sticky watchdog flag
// Optional feature macro: BUS_WATCHDOG_EN (bus watchdog with forced READY
// release and sticky bus_err). Without it bus_err is tied low.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no bus cycle in progress
// ADDR   | address latched, waiting for a rising read/write strobe
// WAIT   | strobe seen on a region with wait states, READY held low
// ACTIVE | strobe in progress with READY high, waiting for its release
module mux_bus_decoder
  import mux_bus_pkg::*;
#(
  parameter int unsigned           NUM_CS   = 2,
  parameter logic [NUM_CS*8-1:0]   CS_BASE  = {8'h01, 8'h00},
  parameter logic [NUM_CS*8-1:0]   CS_MASK  = {8'hFF, 8'hFF},
  parameter logic [NUM_CS-1:0]     CS_IO    = 2'b00,
  parameter logic [NUM_CS*4-1:0]   WAIT_CYC = {4'd1, 4'd0},
  parameter int unsigned           TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                resetn,
  mux_bus_decoder_if.slave    bus,
  output logic [15:0]         address,
  output logic [NUM_CS-1:0]   cs_n,
  output logic                hit,
  output logic                bus_err
);

  if ((NUM_CS < 1) || (NUM_CS > MAX_CS) || (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_cfg
    $error("mux_bus_decoder: NUM_CS must be 1..8 and TIMEOUT 1..65535");
  end

  bus_state_t        state_q;
  logic [15:0]       addr_q;
  logic              io_q;
  logic              ale_q;
  logic              strobe_q;
  logic [NUM_CS-1:0] cs_n_q;
  logic              hit_q;
  logic              ready_q;

  logic              strobe;
  logic              strobe_edge;
  logic              hit_d;
  logic [2:0]        sel_d;
  logic [NUM_CS-1:0] cs_n_d;
  logic [WAIT_W-1:0] wait_sel;
  logic              go_wait;
  logic              ws_zero;
  logic              wd_timeout;

  // Both strobes low together is still a single access.
  assign strobe      = ~bus.rd_n | ~bus.wr_n;
  assign strobe_edge = strobe & ~strobe_q;

  // Decode works on the latched address so it is valid from the first
  // cycle after ALE, even if the strobe falls in that same cycle.
  // Scanning from the top down leaves the lowest matching index in sel_d.
  always_comb begin
    hit_d = 1'b0;
    sel_d = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (region_match(CS_BASE[i*8 +: 8], CS_MASK[i*8 +: 8], addr_q[15:8]) &&
          (io_q == CS_IO[i])) begin
        hit_d = 1'b1;
        sel_d = 3'(i);
      end
    end
    cs_n_d   = hit_d ? ~(NUM_CS'(1) << sel_d) : '1;
    wait_sel = WAIT_CYC[int'(sel_d)*WAIT_W +: WAIT_W];
  end

  assign go_wait = (state_q == ADDR) && !bus.ale && strobe_edge &&
                   hit_d && (wait_sel != '0);

  ws_counter #(.W(WAIT_W)) u_ws (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (go_wait),
    .dec_i      (state_q == WAIT),
    .load_val_i (wait_sel - WAIT_W'(1)),
    .zero_o     (ws_zero)
  );

`ifdef BUS_WATCHDOG_EN
  logic wd_run;
  logic wd_zero;
  logic bus_err_q;

  // Reloaded whenever idle or strobe-free, so it measures one continuous strobe.
  assign wd_run = strobe && (state_q != IDLE);

  ws_counter #(.W(16)) u_wd (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (!wd_run),
    .dec_i      (wd_run),
    .load_val_i (16'(TIMEOUT - 1)),
    .zero_o     (wd_zero)
  );

  assign wd_timeout = wd_run && wd_zero;
  assign bus_err    = bus_err_q;
`else
  assign wd_timeout = 1'b0;
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      io_q     <= 1'b0;
      ale_q    <= 1'b0;
      strobe_q <= 1'b0;
      cs_n_q   <= '1;
      hit_q    <= 1'b0;
      ready_q  <= 1'b1;
`ifdef BUS_WATCHDOG_EN
      bus_err_q <= 1'b0;
`endif
    end else begin
      ale_q    <= bus.ale;
      strobe_q <= strobe;

      if (bus.ale) begin
        addr_q <= {bus.a_hi, bus.ad};
        io_q   <= bus.io_mn;
      end

      // Selects change only on the first cycle after ALE falls.
      if (ale_q && !bus.ale) begin
        cs_n_q <= cs_n_d;
        hit_q  <= hit_d;
      end

`ifdef BUS_WATCHDOG_EN
      if (wd_timeout) begin
        bus_err_q <= 1'b1;
      end
`endif

      if (bus.ale) begin
        state_q <= ADDR;
        ready_q <= 1'b1;
      end else if (wd_timeout) begin
        state_q <= ACTIVE;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: ;
          ADDR: begin
            if (strobe_edge) begin
              if (go_wait) begin
                state_q <= WAIT;
                ready_q <= 1'b0;
              end else begin
                state_q <= ACTIVE;
              end
            end
          end
          WAIT: begin
            if (!strobe) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end else if (ws_zero) begin
              state_q <= ACTIVE;
              ready_q <= 1'b1;
            end
          end
          ACTIVE: begin
            if (!strobe) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign address   = addr_q;
  assign cs_n      = cs_n_q;
  assign hit       = hit_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_mux_bus_decoder.sv
// Testbench for mux_bus_decoder. Two instances share the same stimulus:
//   dut_a : default parameters (region 0 no waits, region 1 one wait)
//   dut_b : region 0 fifteen waits, region 1 five waits, TIMEOUT 8
module tb_mux_bus_decoder;
  import mux_bus_pkg::*;

  logic        clk;
  logic        resetn;
  logic [15:0] addr_a, addr_b;
  logic [1:0]  cs_a, cs_b;
  logic        hit_a, hit_b;
  logic        err_a, err_b;

  int checks   = 0;
  int failures = 0;

  mux_bus_decoder_if bus_a ();
  mux_bus_decoder_if bus_b ();

  mux_bus_decoder dut_a (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus_a),
    .address (addr_a),
    .cs_n    (cs_a),
    .hit     (hit_a),
    .bus_err (err_a)
  );

  mux_bus_decoder #(
    .WAIT_CYC ({4'd5, 4'd15}),
    .TIMEOUT  (8)
  ) dut_b (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus_b),
    .address (addr_b),
    .cs_n    (cs_b),
    .hit     (hit_b),
    .bus_err (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        ale;
    logic [7:0]  ahi;
    logic [7:0]  ad;
    logic        io;
    logic        rd;
    logic        wr;
    logic        chk_cs;
    logic [15:0] e_addr;
    logic [1:0]  e_cs;
    logic        e_hit;
    logic        e_rdy;
  } vec_t;

  localparam int NV = 37;
  vec_t vt [NV];

  function automatic vec_t mk(input logic rstn, input logic ale,
                              input logic [7:0] ahi, input logic [7:0] ad,
                              input logic io, input logic rd, input logic wr,
                              input logic chk_cs, input logic [15:0] e_addr,
                              input logic [1:0] e_cs, input logic e_hit,
                              input logic e_rdy);
    vec_t v;
    v.rstn = rstn; v.ale = ale; v.ahi = ahi; v.ad = ad; v.io = io;
    v.rd = rd; v.wr = wr; v.chk_cs = chk_cs; v.e_addr = e_addr;
    v.e_cs = e_cs; v.e_hit = e_hit; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic drive(input logic ale, input logic [7:0] ahi, input logic [7:0] ad,
                       input logic io, input logic rd, input logic wr);
    bus_a.ale = ale; bus_a.a_hi = ahi; bus_a.ad = ad;
    bus_a.io_mn = io; bus_a.rd_n = rd; bus_a.wr_n = wr;
    bus_b.ale = ale; bus_b.a_hi = ahi; bus_b.ad = ad;
    bus_b.io_mn = io; bus_b.rd_n = rd; bus_b.wr_n = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin
    int n;

    // T1 reset, T2 region0 read, T3 region1 wait, T4 unmapped / IO,
    // both strobes, ALE over strobe edge, last ALE sample kept.
    vt[0]  = mk(0, 1, 8'h12, 8'h34, 0, 1, 1, 1, 16'h0000, 2'b11, 0, 1);
    vt[1]  = mk(1, 1, 8'h00, 8'h34, 0, 1, 1, 0, 16'h0034, 2'b11, 0, 1);
    vt[2]  = mk(1, 0, 8'h00, 8'h34, 0, 1, 1, 1, 16'h0034, 2'b10, 1, 1);
    vt[3]  = mk(1, 0, 8'h00, 8'h34, 0, 0, 1, 1, 16'h0034, 2'b10, 1, 1);
    vt[4]  = mk(1, 0, 8'h00, 8'h34, 0, 0, 1, 1, 16'h0034, 2'b10, 1, 1);
    vt[5]  = mk(1, 0, 8'h00, 8'h34, 0, 1, 1, 1, 16'h0034, 2'b10, 1, 1);
    vt[6]  = mk(1, 1, 8'h01, 8'h00, 0, 1, 1, 0, 16'h0100, 2'b10, 1, 1);
    vt[7]  = mk(1, 0, 8'h01, 8'h00, 0, 1, 1, 1, 16'h0100, 2'b01, 1, 1);
    vt[8]  = mk(1, 0, 8'h01, 8'h00, 0, 0, 1, 1, 16'h0100, 2'b01, 1, 0);
    vt[9]  = mk(1, 0, 8'h01, 8'h00, 0, 0, 1, 1, 16'h0100, 2'b01, 1, 1);
    vt[10] = mk(1, 0, 8'h01, 8'h00, 0, 0, 1, 1, 16'h0100, 2'b01, 1, 1);
    vt[11] = mk(1, 0, 8'h01, 8'h00, 0, 1, 1, 1, 16'h0100, 2'b01, 1, 1);
    vt[12] = mk(1, 1, 8'h80, 8'h00, 0, 1, 1, 0, 16'h8000, 2'b01, 1, 1);
    vt[13] = mk(1, 0, 8'h80, 8'h00, 0, 1, 1, 1, 16'h8000, 2'b11, 0, 1);
    vt[14] = mk(1, 0, 8'h80, 8'h00, 0, 0, 1, 1, 16'h8000, 2'b11, 0, 1);
    vt[15] = mk(1, 0, 8'h80, 8'h00, 0, 1, 1, 1, 16'h8000, 2'b11, 0, 1);
    vt[16] = mk(1, 1, 8'h00, 8'h10, 1, 1, 1, 0, 16'h0010, 2'b11, 0, 1);
    vt[17] = mk(1, 0, 8'h00, 8'h10, 1, 1, 1, 1, 16'h0010, 2'b11, 0, 1);
    vt[18] = mk(1, 0, 8'h00, 8'h10, 1, 1, 0, 1, 16'h0010, 2'b11, 0, 1);
    vt[19] = mk(1, 0, 8'h00, 8'h10, 1, 1, 1, 1, 16'h0010, 2'b11, 0, 1);
    vt[20] = mk(1, 1, 8'h01, 8'h55, 0, 1, 1, 0, 16'h0155, 2'b11, 0, 1);
    vt[21] = mk(1, 0, 8'h01, 8'h55, 0, 1, 1, 1, 16'h0155, 2'b01, 1, 1);
    vt[22] = mk(1, 0, 8'h01, 8'h55, 0, 0, 0, 1, 16'h0155, 2'b01, 1, 0);
    vt[23] = mk(1, 0, 8'h01, 8'h55, 0, 0, 0, 1, 16'h0155, 2'b01, 1, 1);
    vt[24] = mk(1, 0, 8'h01, 8'h55, 0, 1, 1, 1, 16'h0155, 2'b01, 1, 1);
    vt[25] = mk(1, 1, 8'h01, 8'h66, 0, 1, 1, 0, 16'h0166, 2'b01, 1, 1);
    vt[26] = mk(1, 0, 8'h01, 8'h66, 0, 1, 1, 1, 16'h0166, 2'b01, 1, 1);
    vt[27] = mk(1, 1, 8'h01, 8'h77, 0, 0, 1, 0, 16'h0177, 2'b01, 1, 1);
    vt[28] = mk(1, 0, 8'h01, 8'h77, 0, 0, 1, 1, 16'h0177, 2'b01, 1, 1);
    vt[29] = mk(1, 0, 8'h01, 8'h77, 0, 0, 1, 1, 16'h0177, 2'b01, 1, 1);
    vt[30] = mk(1, 0, 8'h01, 8'h77, 0, 1, 1, 1, 16'h0177, 2'b01, 1, 1);
    vt[31] = mk(1, 1, 8'h00, 8'h11, 0, 1, 1, 0, 16'h0011, 2'b01, 1, 1);
    vt[32] = mk(1, 1, 8'h01, 8'h22, 0, 1, 1, 0, 16'h0122, 2'b01, 1, 1);
    vt[33] = mk(1, 0, 8'h01, 8'h22, 0, 1, 1, 1, 16'h0122, 2'b01, 1, 1);
    vt[34] = mk(1, 0, 8'h01, 8'h22, 0, 0, 1, 1, 16'h0122, 2'b01, 1, 0);
    vt[35] = mk(1, 0, 8'h01, 8'h22, 0, 0, 1, 1, 16'h0122, 2'b01, 1, 1);
    vt[36] = mk(1, 0, 8'h01, 8'h22, 0, 1, 1, 1, 16'h0122, 2'b01, 1, 1);

    resetn = 1'b0;
    drive(0, 8'h00, 8'h00, 0, 1, 1);
    tick();
    tick();

    for (int i = 0; i < NV; i++) begin
      resetn = vt[i].rstn;
      drive(vt[i].ale, vt[i].ahi, vt[i].ad, vt[i].io, vt[i].rd, vt[i].wr);
      tick();
      check($sformatf("row%0d_addr", i), 32'(addr_a), 32'(vt[i].e_addr));
      check($sformatf("row%0d_ready", i), 32'(bus_a.ready), 32'(vt[i].e_rdy));
      if (vt[i].chk_cs) begin
        check($sformatf("row%0d_cs_n", i), 32'(cs_a), 32'(vt[i].e_cs));
        check($sformatf("row%0d_hit", i), 32'(hit_a), 32'(vt[i].e_hit));
      end
    end
    check("a_bus_err_low", 32'(err_a), 32'd0);

    // Region 1 on dut_b: READY low for exactly five cycles.
    drive(1, 8'h01, 8'h00, 0, 1, 1); tick();
    drive(0, 8'h01, 8'h00, 0, 1, 1); tick();
    check("b_cs_region1", 32'(cs_b), 32'h1);
    drive(0, 8'h01, 8'h00, 0, 0, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus_b.ready == 1'b0) n++;
      else break;
    end
    check("b_wait_len5", 32'(n), 32'd5);
    drive(0, 8'h01, 8'h00, 0, 1, 1); tick();
    check("b_ready_after_wait", 32'(bus_b.ready), 32'd1);

    // Strobe released after two waits: READY returns next cycle, FSM idle.
    drive(1, 8'h01, 8'h00, 0, 1, 1); tick();
    drive(0, 8'h01, 8'h00, 0, 1, 1); tick();
    drive(0, 8'h01, 8'h00, 0, 0, 1); tick();
    check("abort_wait1", 32'(bus_b.ready), 32'd0);
    tick();
    check("abort_wait2", 32'(bus_b.ready), 32'd0);
    drive(0, 8'h01, 8'h00, 0, 1, 1); tick();
    check("abort_ready", 32'(bus_b.ready), 32'd1);
    drive(0, 8'h01, 8'h00, 0, 0, 1); tick(); tick();
    check("abort_idle_no_wait", 32'(bus_b.ready), 32'd1);
    drive(0, 8'h01, 8'h00, 0, 1, 1); tick();

    // Reset pulsed mid-WAIT.
    drive(1, 8'h01, 8'h00, 0, 1, 1); tick();
    drive(0, 8'h01, 8'h00, 0, 1, 1); tick();
    drive(0, 8'h01, 8'h00, 0, 0, 1); tick();
    tick();
    check("rst_mid_wait_pre", 32'(bus_b.ready), 32'd0);
    resetn = 1'b0; tick();
    check("rst_addr", 32'(addr_b), 32'd0);
    check("rst_cs_n", 32'(cs_b), 32'h3);
    check("rst_hit", 32'(hit_b), 32'd0);
    check("rst_ready", 32'(bus_b.ready), 32'd1);
    check("rst_bus_err", 32'(err_b), 32'd0);
    resetn = 1'b1; tick(); tick();
    check("rst_held_strobe_ready", 32'(bus_b.ready), 32'd1);
    drive(0, 8'h00, 8'h00, 0, 1, 1); tick();

`ifdef BUS_WATCHDOG_EN
    // Region 0 on dut_b has fifteen waits; the watchdog (TIMEOUT 8) frees it.
    drive(1, 8'h00, 8'h00, 0, 1, 1); tick();
    drive(0, 8'h00, 8'h00, 0, 1, 1); tick();
    check("wd_cs_region0", 32'(cs_b), 32'h2);
    drive(0, 8'h00, 8'h00, 0, 1, 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus_b.ready == 1'b0) n++;
      else break;
    end
    check("wd_low_cycles", 32'(n), 32'd7);
    check("wd_bus_err_set", 32'(err_b), 32'd1);
    drive(0, 8'h00, 8'h00, 0, 1, 1); tick();
    drive(1, 8'h80, 8'h00, 0, 1, 1); tick();
    drive(0, 8'h80, 8'h00, 0, 1, 1); tick();
    check("wd_bus_err_sticky", 32'(err_b), 32'd1);
    resetn = 1'b0; tick();
    check("wd_bus_err_reset", 32'(err_b), 32'd0);
    resetn = 1'b1; tick();
`else
    check("b_bus_err_tied", 32'(err_b), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
